// File: rtl/sm3_pkg.sv
// SM3 shared definitions: IV, controller state enum and the
// 32-bit helper functions used by the compression datapath.
package sm3_pkg;

  localparam logic [255:0] SM3_IV = {
    32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
    32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } sm3_ctrl_state_t;

  // A shift by 32 yields zero, so n == 0 returns x unchanged.
  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
  endfunction

endpackage

// File: rtl/sm3_block.sv
// SM3 compression function CF(V, B), purely combinational.
// Ports: data (512b block), state_init (V), state_res (V').
module sm3_block
  import sm3_pkg::*;
(
  input  logic [511:0] data,
  input  logic [255:0] state_init,
  output logic [255:0] state_res
);

  function automatic logic [255:0] cf(
    input logic [255:0] v,
    input logic [511:0] m
  );
    logic [31:0] w [68];
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] ss1, ss2, tt1, tt2, tj, fv, gv;
    for (int j = 0; j < 16; j++)
      w[j] = m[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 5'd15))
           ^ rotl(w[j-13], 5'd7) ^ w[j-6];
    {a, b, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      if (j < 16) begin
        tj = 32'h79cc4519;
        fv = a ^ b ^ c;
        gv = e ^ f ^ g;
      end else begin
        tj = 32'h7a879d8a;
        fv = (a & b) | (a & c) | (b & c);
        gv = (e & f) | (~e & g);
      end
      ss1 = rotl(rotl(a, 5'd12) + e + rotl(tj, 5'(j)), 5'd7);
      ss2 = ss1 ^ rotl(a, 5'd12);
      tt1 = fv + d + ss2 + (w[j] ^ w[j+4]);
      tt2 = gv + h + ss1 + w[j];
      d = c;
      c = rotl(b, 5'd9);
      b = a;
      a = tt1;
      h = g;
      g = rotl(f, 5'd19);
      f = e;
      e = p0(tt2);
    end
    return v ^ {a, b, c, d, e, f, g, h};
  endfunction

  assign state_res = cf(state_init, data);

endmodule

// File: rtl/sm3_ctrl.sv
// Multi-block SM3 sequencer: block stream in, digest stream out.
// Ports: clk, rst_n, blk_* (valid/ready/data/first/last), dgst_*, busy.
module sm3_ctrl
  import sm3_pkg::*;
#(
  // Cycles given to the combinational CF path; legal 1..16.
  parameter int unsigned COMPUTE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         dgst_valid,
  input  logic         dgst_ready,
  output logic [255:0] dgst,
  output logic         busy
);

  localparam logic [3:0] CNT_INIT = 4'(COMPUTE_CYCLES - 1);

  sm3_ctrl_state_t state_q;
  logic [511:0]    data_q;
  logic [255:0]    init_q;
  logic [255:0]    chain_q;
  logic [255:0]    dgst_q;
  logic            last_q;
  logic [3:0]      cnt_q;
  logic            blk_ready_q;
  logic            dgst_valid_q;
  logic            busy_q;
  logic [255:0]    state_res;

  // data_q/init_q are held through CALC; state_res is a
  // multicycle path of COMPUTE_CYCLES into chain_q/dgst_q.
  sm3_block u_block (
    .data       (data_q),
    .state_init (init_q),
    .state_res  (state_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      init_q       <= SM3_IV;
      chain_q      <= SM3_IV;
      dgst_q       <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      blk_ready_q  <= 1'b1;
      dgst_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (blk_valid) begin
            data_q      <= blk_data;
            init_q      <= blk_first ? SM3_IV : chain_q;
            last_q      <= blk_last;
            cnt_q       <= CNT_INIT;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CALC;
          end
        end
        CALC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            chain_q <= state_res;
            if (last_q) begin
              dgst_q       <= state_res;
              dgst_valid_q <= 1'b1;
              state_q      <= OUT;
            end else begin
              blk_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        OUT: begin
          if (dgst_ready) begin
            // Next message may omit blk_first and still start at IV.
            chain_q      <= SM3_IV;
            dgst_valid_q <= 1'b0;
            blk_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign blk_ready  = blk_ready_q;
  assign dgst_valid = dgst_valid_q;
  assign dgst       = dgst_q;
  assign busy       = busy_q;

endmodule
